// File: rtl/cf_pkg.sv
// Shared constants for the cf threshold-vote filter.
// Input registering is optional via the CF_INPUT_REG_EN macro.
package cf_pkg;

   localparam int N_IN                  = 9;
   localparam int CNT_W                 = 4;
   localparam int DEFAULT_THRESHOLD     = 5;
   localparam int DEFAULT_FILTER_CYCLES = 1;

   localparam int THRESHOLD_MIN = 1;
   localparam int THRESHOLD_MAX = N_IN;
   localparam int FILTER_MIN    = 1;
   localparam int FILTER_MAX    = 15;

   function automatic bit in_range(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/cf_popcount.sv
// Combinational population count of the vote vector.
module cf_popcount
   import cf_pkg::*;
(
   input  logic [N_IN-1:0]  bits,
   output logic [CNT_W-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N_IN; i++) begin
         cnt = cnt + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/cf.sv
// Threshold vote over nine inputs with a persistence filter on the result.
// Define CF_INPUT_REG_EN to register the inputs ahead of the count (+1 cycle latency).
module cf
   import cf_pkg::*;
#(
   parameter int THRESHOLD     = DEFAULT_THRESHOLD,
   parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic I0,
   input  logic I1,
   input  logic I2,
   input  logic I3,
   input  logic I4,
   input  logic I5,
   input  logic I6,
   input  logic I7,
   input  logic I8,
   output logic Y
);

   generate
      if (!in_range(THRESHOLD, THRESHOLD_MIN, THRESHOLD_MAX)) begin : g_bad_threshold
         $error("cf: THRESHOLD out of range 1..9");
      end
      if (!in_range(FILTER_CYCLES, FILTER_MIN, FILTER_MAX)) begin : g_bad_filter
         $error("cf: FILTER_CYCLES out of range 1..15");
      end
   endgenerate

   localparam logic [CNT_W-1:0] TH      = CNT_W'(THRESHOLD);
   localparam logic [CNT_W-1:0] PC_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [N_IN-1:0]  vin;
   logic [N_IN-1:0]  vote;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pc;
   logic             raw;

   assign vin = {I8, I7, I6, I5, I4, I3, I2, I1, I0};

`ifdef CF_INPUT_REG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vote <= '0;
      end else begin
         vote <= vin;
      end
   end
`else
   assign vote = vin;
`endif

   cf_popcount u_popcount (
      .bits (vote),
      .cnt  (cnt)
   );

   assign raw = (cnt >= TH);

   // pc counts consecutive disagreeing cycles; Y flips on the FILTER_CYCLES-th one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Y  <= 1'b0;
         pc <= '0;
      end else if (raw == Y) begin
         pc <= '0;
      end else if (pc == PC_LAST) begin
         Y  <= raw;
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

endmodule

// File: tb/tb_cf.sv
// Scoreboard bench for cf: three instances (defaults, FILTER_CYCLES=3, THRESHOLD=9)
// share one input vector; expected Y per cycle is queued by stimulus and popped by a monitor.
module tb_cf;

   typedef struct packed {
      logic       rst;
      logic [8:0] vec;
      logic       ya;
      logic       yb;
      logic       yc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] vec = '0;
   logic       ya, yb, yc;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cf u_a (
      .clk(clk), .rst_n(rst_n),
      .I0(vec[0]), .I1(vec[1]), .I2(vec[2]), .I3(vec[3]), .I4(vec[4]),
      .I5(vec[5]), .I6(vec[6]), .I7(vec[7]), .I8(vec[8]),
      .Y(ya)
   );

   cf #(.FILTER_CYCLES(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .I0(vec[0]), .I1(vec[1]), .I2(vec[2]), .I3(vec[3]), .I4(vec[4]),
      .I5(vec[5]), .I6(vec[6]), .I7(vec[7]), .I8(vec[8]),
      .Y(yb)
   );

   cf #(.THRESHOLD(9)) u_c (
      .clk(clk), .rst_n(rst_n),
      .I0(vec[0]), .I1(vec[1]), .I2(vec[2]), .I3(vec[3]), .I4(vec[4]),
      .I5(vec[5]), .I6(vec[6]), .I7(vec[7]), .I8(vec[8]),
      .Y(yc)
   );

   task automatic chk(input string name, input int idx, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s step %0d: Y=%b expected %b", name, idx, act, req);
      end
   endtask

   // With registered inputs every result lags one cycle, except reset cycles which force 0.
   initial begin : monitor
      exp_t cur, prev, use_e;
      int   idx;
      prev = '0;
      idx  = 0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            cur = q.pop_front();
            idx++;
`ifdef CF_INPUT_REG_EN
            use_e = cur.rst ? '0 : prev;
`else
            use_e = cur;
`endif
            if (cur.rst) begin
               use_e.ya = 1'b0;
               use_e.yb = 1'b0;
               use_e.yc = 1'b0;
            end
            chk("dflt",  idx, ya, use_e.ya);
            chk("filt3", idx, yb, use_e.yb);
            chk("th9",   idx, yc, use_e.yc);
            prev = cur;
         end
      end
   end

   task automatic step(input logic rst, input logic [8:0] v,
                       input logic ea, input logic eb, input logic ec);
      exp_t e;
      @(negedge clk);
      rst_n = ~rst;
      vec   = v;
      e.rst = rst; e.vec = v; e.ya = ea; e.yb = eb; e.yc = ec;
      q.push_back(e);
   endtask

   localparam logic [8:0] ONES = 9'b111111111;
   localparam logic [8:0] ZERO = 9'b000000000;
   localparam logic [8:0] C5   = 9'b110101010;
   localparam logic [8:0] C6   = 9'b100111011;
   localparam logic [8:0] C4   = 9'b011110000;
   localparam logic [8:0] C8   = 9'b111111110;

   initial begin : stim
      //    rst  vec   dflt f3 th9
      step(1'b1, ONES, 0, 0, 0);
      step(1'b1, ONES, 0, 0, 0);
      step(1'b1, ONES, 0, 0, 0);
      step(1'b0, C5,   1, 0, 0);
      step(1'b0, C6,   1, 0, 0);
      step(1'b0, C4,   0, 0, 0);
      step(1'b0, ZERO, 0, 0, 0);
      // two-cycle pulse must not pass the 3-cycle filter
      step(1'b0, C5,   1, 0, 0);
      step(1'b0, C5,   1, 0, 0);
      step(1'b0, ZERO, 0, 0, 0);
      step(1'b0, C5,   1, 0, 0);
      step(1'b0, C5,   1, 0, 0);
      step(1'b0, C5,   1, 1, 0);
      step(1'b0, ONES, 1, 1, 1);
      // reset mid-run while all outputs are high
      step(1'b1, ONES, 0, 0, 0);
      step(1'b0, ONES, 1, 0, 1);
      step(1'b0, ONES, 1, 0, 1);
      step(1'b0, C8,   1, 1, 0);
      step(1'b0, ONES, 1, 1, 1);
      step(1'b0, ZERO, 0, 1, 0);
      step(1'b0, C5,   1, 1, 0);
      step(1'b0, ZERO, 0, 1, 0);
      step(1'b0, ZERO, 0, 1, 0);
      step(1'b0, ZERO, 0, 0, 0);
      step(1'b0, ZERO, 0, 0, 0);
      repeat (3) @(negedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
